// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Two requesters share one 32-bit ALU; result held in a
//            single registered response slot with valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int RR_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req0_op,
    input  logic [3:0]  req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_id
);

    localparam logic [0:0] c_EMPTY = 1'b0;
    localparam logic [0:0] c_FULL  = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;
    logic        r_last;
    logic [31:0] r_result;
    logic        r_zero;
    logic        r_id;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_slot_free;
    logic        w_accept0;
    logic        w_accept1;
    logic        w_accept;
    logic [31:0] w_alu0;
    logic [31:0] w_alu1;
    logic [31:0] w_sel;

    function automatic logic [31:0] alu_calc(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [3:0]  op);
        logic [31:0] res;
        case (op)
            4'b0000: res = a + b;
            4'b0001: res = a - b;
            4'b0010: res = a & b;
            4'b0011: res = a | b;
            4'b0100: res = a ^ b;
            4'b0101: res = a << b[4:0];
            4'b0110: res = a >> b[4:0];
            4'b0111: res = $unsigned($signed(a) >>> b[4:0]);
            4'b1000: res = {31'd0, ($signed(a) < $signed(b))};
            4'b1001: res = {31'd0, (a < b)};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    assign w_alu0 = alu_calc(req0_a, req0_b, req0_op);
    assign w_alu1 = alu_calc(req1_a, req1_b, req1_op);

    // On a tie, round-robin favours whoever was not served by the last accept.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            if ((RR_EN != 0) && (r_last == 1'b0)) w_grant1 = 1'b1;
            else                                   w_grant0 = 1'b1;
        end else begin
            w_grant0 = req0_valid;
            w_grant1 = req1_valid;
        end
    end

    assign w_slot_free = ((r_state == c_EMPTY) || rsp_ready) && !flush && !rst;
    assign w_accept0   = req0_valid && req0_ready;
    assign w_accept1   = req1_valid && req1_ready;
    assign w_accept    = w_accept0 || w_accept1;
    assign w_sel       = w_accept1 ? w_alu1 : w_alu0;

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_EMPTY;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = c_EMPTY;
        end else if (r_state == c_EMPTY) begin
            if (w_accept) w_state_next = c_FULL;
        end else begin
            if (w_accept)       w_state_next = c_FULL;
            else if (rsp_ready) w_state_next = c_EMPTY;
        end
    end

    always_comb begin
        rsp_valid  = (r_state == c_FULL);
        req0_ready = w_grant0 && w_slot_free;
        req1_ready = w_grant1 && w_slot_free;
    end

    // Data registers only move on an accept; a drain leaves them untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= 32'd0;
            r_zero   <= 1'b0;
            r_id     <= 1'b0;
            r_last   <= 1'b1;
        end else if (w_accept) begin
            r_result <= w_sel;
            r_zero   <= (w_sel == 32'd0);
            r_id     <= w_accept1;
            r_last   <= w_accept1;
        end
    end

    assign rsp_result = r_result;
    assign rsp_zero   = r_zero;
    assign rsp_id     = r_id;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Self-checking bench for alu_arbiter with a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_id;

    logic        fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_zero, fp_rsp_id;
    logic [31:0] fp_rsp_result;

    typedef struct packed {
        logic        id;
        logic [31:0] res;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        m_valid = 1'b0;
    logic        m_last  = 1'b1;
    logic [31:0] m_res   = 32'd0;
    logic        m_id    = 1'b0;

    alu_arbiter #(.RR_EN(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_id(rsp_id)
    );

    alu_arbiter #(.RR_EN(0)) dut_fp (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(fp_req0_ready), .req1_ready(fp_req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(fp_rsp_result), .rsp_zero(fp_rsp_zero), .rsp_id(fp_rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] op);
        logic signed [31:0] sa;
        sa = a;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a + ~b + 32'd1;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return sa >>> b[4:0];
            4'd8:    return (sa < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // One clock: check readies before the edge, then the response after it.
    task automatic step();
        logic eg0, eg1, free, er0, er1, take;
        exp_t e;
        @(negedge clk);
        free = (!m_valid || rsp_ready) && !flush && !rst;
        if (req0_valid && req1_valid) begin
            eg0 = (m_last == 1'b1);
            eg1 = !eg0;
        end else begin
            eg0 = req0_valid;
            eg1 = req1_valid;
        end
        er0 = eg0 && free;
        er1 = eg1 && free;
        n_cmp++;
        if ({req0_ready, req1_ready} !== {er0, er1}) begin
            n_err++;
            $display("FAIL readies: got %b%b expected %b%b", req0_ready, req1_ready, er0, er1);
        end
        take = er0 || er1;
        if (er0) q.push_back({1'b0, model_alu(req0_a, req0_b, req0_op)});
        if (er1) q.push_back({1'b1, model_alu(req1_a, req1_b, req1_op)});
        if (rst) begin
            m_valid = 1'b0; m_last = 1'b1; m_res = 32'd0; m_id = 1'b0;
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (take) begin
            m_valid = 1'b1; m_last = er1;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (rsp_valid !== m_valid) begin
            n_err++;
            $display("FAIL rsp_valid: got %b expected %b", rsp_valid, m_valid);
        end
        if (take) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard: accept with empty queue");
            end else begin
                e = q.pop_front();
                m_res = e.res;
                m_id  = e.id;
            end
        end
        if (m_valid) begin
            n_cmp++;
            if ({rsp_id, rsp_zero, rsp_result} !== {m_id, (m_res == 32'd0), m_res}) begin
                n_err++;
                $display("FAIL rsp_data: got id=%b zero=%b res=%h expected id=%b zero=%b res=%h",
                         rsp_id, rsp_zero, rsp_result, m_id, (m_res == 32'd0), m_res);
            end
        end
    endtask

    task automatic drive0(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        req0_a = a; req0_b = b; req0_op = op;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        drive0(32'd9, 32'd4, 4'd0);
        req1_a = 32'd20; req1_b = 32'd1; req1_op = 4'd1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (rsp_result !== 32'd0) begin
                n_err++;
                $display("FAIL reset_result: got %h expected 0", rsp_result);
            end
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (rsp_id !== 1'b0) begin
            n_err++;
            $display("FAIL reset_first_grant: got id %b expected 0", rsp_id);
        end
    endtask

    task automatic test_single();
        req1_valid = 1'b0; req0_valid = 1'b1; rsp_ready = 1'b1;
        drive0(32'd5, 32'd3, 4'b0001);
        step();
        n_cmp++;
        if ({rsp_valid, rsp_result, rsp_zero, rsp_id} !== {1'b1, 32'd2, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL single_sub: got v=%b res=%h z=%b id=%b expected 1 2 0 0",
                     rsp_valid, rsp_result, rsp_zero, rsp_id);
        end
        drive0(32'd7, 32'd7, 4'b0001);
        step();
        n_cmp++;
        if (rsp_zero !== 1'b1) begin
            n_err++;
            $display("FAIL single_zero: got %b expected 1", rsp_zero);
        end
    endtask

    task automatic test_arbitration();
        logic exp_id [4];
        exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req0_a = 32'(i); req1_a = 32'(i + 100);
            step();
            n_cmp++;
            if (rsp_id !== exp_id[i]) begin
                n_err++;
                $display("FAIL rr_id[%0d]: got %b expected %b", i, rsp_id, exp_id[i]);
            end
            n_cmp++;
            if ({fp_rsp_valid, fp_rsp_id} !== 2'b10) begin
                n_err++;
                $display("FAIL fixed_id[%0d]: got v=%b id=%b expected v=1 id=0",
                         i, fp_rsp_valid, fp_rsp_id);
            end
        end
    endtask

    task automatic test_backpressure();
        req0_valid = 1'b1; req1_valid = 1'b0; rsp_ready = 1'b1;
        drive0(32'h1234, 32'h1, 4'd0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b1; rsp_ready = 1'b0;
        req1_a = 32'hF0; req1_b = 32'h0F; req1_op = 4'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({rsp_result, rsp_id} !== {32'h1235, 1'b0}) begin
                n_err++;
                $display("FAIL hold[%0d]: got res=%h id=%b expected 00001235 0", i, rsp_result, rsp_id);
            end
        end
        rsp_ready = 1'b1;
        step();
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b1, 32'hFF}) begin
            n_err++;
            $display("FAIL drain_accept: got v=%b id=%b res=%h expected 1 1 000000ff",
                     rsp_valid, rsp_id, rsp_result);
        end
        req1_valid = 1'b0;
        step();
    endtask

    task automatic test_alu();
        logic [3:0]  ops [4];
        logic [31:0] as  [4];
        logic [31:0] bs  [4];
        logic [31:0] ex  [4];
        ops = '{4'b0111, 4'b1000, 4'b1001, 4'b1111};
        as  = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678};
        bs  = '{32'd4, 32'd1, 32'd1, 32'h9};
        ex  = '{32'hF8000000, 32'd1, 32'd0, 32'd0};
        req0_valid = 1'b1; req1_valid = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive0(as[i], bs[i], ops[i]);
            step();
            n_cmp++;
            if ({rsp_result, rsp_zero} !== {ex[i], (ex[i] == 32'd0)}) begin
                n_err++;
                $display("FAIL alu_corner[%0d]: got res=%h z=%b expected %h", i, rsp_result, rsp_zero, ex[i]);
            end
        end
        for (int i = 0; i < 40; i++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            rsp_ready  = 1'($urandom_range(0, 3) != 0);
            drive0($urandom, $urandom, 4'($urandom_range(0, 15)));
            req1_a = $urandom; req1_b = $urandom; req1_op = 4'($urandom_range(0, 15));
            step();
        end
    endtask

    task automatic test_flush();
        req0_valid = 1'b1; req1_valid = 1'b0; rsp_ready = 1'b1;
        drive0(32'd1, 32'd1, 4'd0);
        step();
        req1_valid = 1'b1; rsp_ready = 1'b0;
        step();
        flush = 1'b1;
        step();
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_valid: got %b expected 0", rsp_valid);
        end
        flush = 1'b0; rsp_ready = 1'b1;
        step();
        n_cmp++;
        if (rsp_id !== 1'b1) begin
            n_err++;
            $display("FAIL flush_pointer: got id %b expected 1", rsp_id);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        req0_op = '0; req1_op = '0;
        test_reset();
        test_single();
        test_arbitration();
        test_backpressure();
        test_alu();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one parameter: RR_EN, default 1, 1 = round-robin tie-break, 0 = fixed priority to requester 0.
REQ-002 The block SHALL have the port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1, the reset; synchronous and active-high.
REQ-004 The block SHALL have the port flush, input, 1, a synchronous discard of the held response.
REQ-005 The block SHALL have the ports req0_valid, req1_valid, input, 1, each asserting that requester N presents an operation.
REQ-006 The block SHALL have the ports req0_ready, req1_ready, output, 1, each indicating that requester N's operation is accepted this cycle.
REQ-007 The block SHALL have the ports req0_a, req0_b, req1_a, req1_b, input, 32, the operands.
REQ-008 The block SHALL have the ports req0_op, req1_op, input, 4, the ALU operation code.
REQ-009 The block SHALL have the port rsp_valid, output, 1, the held response valid.
REQ-010 The block SHALL have the port rsp_ready, input, 1, the consumer accepting the response.
REQ-011 The block SHALL have the port rsp_result, output, 32, the registered ALU result.
REQ-012 The block SHALL have the port rsp_zero, output, 1, high when rsp_result == 0.
REQ-013 The block SHALL have the port rsp_id, output, 1, the requester that produced the response.

Function
REQ-014 The block SHALL share one 32-bit ALU between two requesters and register its result in a single response slot.
REQ-015 The ALU opcodes SHALL be:
- 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR (ADD/SUB modulo 2^32).
- 0101 SLL, 0110 SRL, 0111 SRA (arithmetic): shift amount = b[4:0].
- 1000 SLT (signed), 1001 SLTU: result 1 or 0.
- 1010-1111: result 0.
REQ-016 Slot free SHALL be defined as (!rsp_valid || rsp_ready) && !flush.
REQ-017 Grant SHALL be decided as follows:
- Only one reqN_valid high: that requester is granted.
- Both high, RR_EN=1: the requester not served by the last accept is granted.
- Both high, RR_EN=0: requester 0 is granted.
- Neither high: no grant.
REQ-018 reqN_ready SHALL equal grantN && slot free, combinationally; at most one ready is high per cycle.
REQ-019 On an accept (reqN_valid && reqN_ready), at the next edge, rsp_result, rsp_zero and rsp_id SHALL be loaded from requester N's ALU output and rsp_valid set to 1: latency of exactly 1 cycle.
REQ-020 The round-robin last-served pointer SHALL update only on an accept; it is unchanged when stalled, flushed or idle.
REQ-021 With rsp_valid=1 and rsp_ready=0, rsp_result, rsp_zero and rsp_id SHALL hold stable and both readies SHALL be 0.
REQ-022 With rsp_valid=1, rsp_ready=1 and a new accept in the same cycle, the slot SHALL be replaced with no bubble, giving full throughput of 1 op/cycle.
REQ-023 With rsp_valid=1, rsp_ready=1 and no accept, rsp_valid SHALL go to 0; the data registers keep their last values.
REQ-024 Response-slot states SHALL be EMPTY (rsp_valid=0) and FULL (rsp_valid=1), with transitions:
- EMPTY->FULL on accept.
- FULL->FULL on hold, or on drain+accept.
- FULL->EMPTY on drain without accept.
- Any state->EMPTY on flush.
REQ-025 flush=1 SHALL clear rsp_valid at the next edge, force both readies to 0 that cycle, and leave the pointer unchanged.
REQ-026 When rst and flush are asserted together, rst SHALL take effect.
REQ-027 Requester inputs SHALL be ignored whenever reqN_ready=0; a requester may change or drop its operation while not accepted.

Reset
REQ-028 While rst=1, at each edge, the block SHALL force rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_id=0, and the pointer to "last served = 1", so requester 0 wins the first tie.
REQ-029 While rst=1, both readies SHALL be 0; reset mid-operation SHALL discard any held response without emitting it.
REQ-030 The first accept SHALL be possible in the first cycle after rst deasserts.

Verification
REQ-031 The bench SHALL cover reset: rst for 2 cycles with both valids high -> readies 0, rsp_valid=0 and rsp_result=0 during reset; after release, req0 is granted first.
REQ-032 The bench SHALL cover a single request: req0 a=5, b=3, op=0001, rsp_ready=1 -> the next cycle gives rsp_valid=1, rsp_result=2, rsp_zero=0, rsp_id=0; with a=b=7, rsp_zero=1.
REQ-033 The bench SHALL cover arbitration: both valid for 4 cycles, rsp_ready=1 -> rsp_id sequence 0,1,0,1 when RR_EN=1, and 0,0,0,0 when RR_EN=0.
REQ-034 The bench SHALL cover backpressure: a held response with rsp_ready=0 for 3 cycles -> output stable and readies 0; rsp_ready=1 with req1 valid -> the same-cycle accept gives rsp_id=1 the next cycle with no empty cycle.
REQ-035 The bench SHALL cover the ALU corner cases:
- SRA a=0x80000000, b=4 -> 0xF8000000.
- SLT a=0xFFFFFFFF, b=1 -> 1; SLTU with the same operands -> 0.
- op=1111 -> result 0, rsp_zero=1.
REQ-036 The bench SHALL cover flush: flush with rsp_valid=1 and both valid -> the next cycle gives rsp_valid=0, no accept that cycle, and an unchanged pointer (the same requester wins the next tie).
